mem_access_stage: RTL

// - Pipeline stage directly downstream of the execute/M-register stage.
// - Consumes regwriteM/resultsrcM/memwriteM/aluresultM/Rd2M/RdM.
// - Performs word loads/stores on a req/gnt/rvalid data-memory bus and stalls upstream while an access is open.
// - Registers writeback-stage signals (regwriteW, RdW, resultW) for the register file.

---
 rtl/rv32i_pkg.sv | 11 +
 rtl/mem_access_stage.sv | 112 +++++++++++
 2 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I datapath widths and the data-memory access FSM encoding.
package rv32i_pkg;
  localparam int DPW = 32;
  localparam int ADW = 5;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RD
  } dmem_state_t;
endpackage

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: word loads/stores over a req/gnt/rvalid bus,
// upstream stall while an access is open, and the registered writeback outputs.
module mem_access_stage
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           regwriteM,
  input  logic           resultsrcM,
  input  logic           memwriteM,
  input  logic [DPW-1:0] aluresultM,
  input  logic [DPW-1:0] Rd2M,
  input  logic [ADW-1:0] RdM,
  output logic           stall_o,
  output logic           dmem_req_o,
  output logic           dmem_we_o,
  output logic [DPW-1:0] dmem_addr_o,
  output logic [DPW-1:0] dmem_wdata_o,
  input  logic           dmem_gnt_i,
  input  logic           dmem_rvalid_i,
  input  logic [DPW-1:0] dmem_rdata_i,
  output logic           regwriteW,
  output logic [ADW-1:0] RdW,
  output logic [DPW-1:0] resultW,
  output logic           dmem_err_o
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  dmem_state_t state, state_n;
  logic [7:0]  cnt;
  logic        access, misaligned, tmo_lim;
  logic        req, done, timeout;

  assign access     = resultsrcM | memwriteM;
  assign misaligned = access & (aluresultM[1:0] != 2'b00);
  // The access in flight has used its whole budget in this cycle.
  assign tmo_lim    = (state != IDLE) && (cnt == TMO_LAST);

  always_comb begin
    state_n = state;
    req     = 1'b0;
    done    = 1'b0;
    timeout = 1'b0;
    case (state)
      IDLE, REQ: begin
        // The request is withdrawn on the abort cycle so the bus never accepts it.
        req = access & ~misaligned & ~tmo_lim;
        if (req && dmem_gnt_i) begin
          done    = memwriteM;
          state_n = memwriteM ? IDLE : WAIT_RD;
        end else if (req) begin
          state_n = REQ;
        end else begin
          state_n = IDLE;
        end
      end
      WAIT_RD: begin
        if (dmem_rvalid_i) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    timeout = tmo_lim & ~done;
    if (timeout) state_n = IDLE;
  end

  assign stall_o      = access & ~misaligned & ~done & ~timeout;
  assign dmem_req_o   = req;
  assign dmem_we_o    = memwriteM;
  assign dmem_addr_o  = {aluresultM[DPW-1:2], 2'b00};
  assign dmem_wdata_o = Rd2M;

  // FSM and timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= (state == IDLE) ? 8'd0 : cnt + 8'd1;
    end
  end

  // Writeback register
  always_ff @(posedge clk) begin
    if (rst) begin
      regwriteW  <= 1'b0;
      RdW        <= '0;
      resultW    <= '0;
      dmem_err_o <= 1'b0;
    end else begin
      dmem_err_o <= misaligned | timeout;
      if (misaligned | timeout | stall_o) begin
        regwriteW <= 1'b0;
      end else if (!access) begin
        regwriteW <= regwriteM;
        RdW       <= RdM;
        resultW   <= aluresultM;
      end else if (done) begin
        regwriteW <= regwriteM;
        RdW       <= RdM;
        resultW   <= memwriteM ? aluresultM : dmem_rdata_i;
      end
    end
  end

endmodule
